// File: rtl/rc4_keystream_decrypt.sv
// RC4 PRGA stage: walks the shuffled S-box, XORs each keystream byte with the
// encrypted ROM byte and stores the plaintext in the decrypted-message RAM.
module rc4_keystream_decrypt #(
  parameter int unsigned MSG_LEN = 32,
  parameter int unsigned ADDR_W  = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  output logic              finish,
  output logic              s_mem_req,
  output logic [7:0]        s_address,
  output logic [7:0]        s_data,
  output logic              s_wen,
  input  logic [7:0]        s_q,
  output logic [ADDR_W-1:0] rom_address,
  input  logic [7:0]        rom_q,
  output logic [ADDR_W-1:0] d_address,
  output logic [7:0]        d_data,
  output logic              d_wen
);

  localparam logic [ADDR_W-1:0] LastK = ADDR_W'(MSG_LEN - 1);

  typedef enum logic [3:0] {
    StIdle, StInit, StRdSi, StWtSi, StLtSi, StRdSj, StWtSj, StLtSj,
    StWrSi, StWrSj, StRdF, StWtF, StLtF, StWrOut, StDone
  } state_e;

  state_e            state;
  logic [7:0]        i, j, si, sj, f;
  logic [ADDR_W-1:0] k;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= StIdle;
      i           <= 8'd0;
      j           <= 8'd0;
      k           <= '0;
      si          <= 8'd0;
      sj          <= 8'd0;
      f           <= 8'd0;
      finish      <= 1'b0;
      s_mem_req   <= 1'b0;
      s_address   <= 8'd0;
      s_data      <= 8'd0;
      s_wen       <= 1'b0;
      rom_address <= '0;
      d_address   <= '0;
      d_data      <= 8'd0;
      d_wen       <= 1'b0;
    end else begin
      case (state)
        StIdle: begin
          if (start) begin
            s_mem_req <= 1'b1;
            state     <= StInit;
          end
        end
        StInit: begin
          i         <= 8'd1;
          j         <= 8'd0;
          k         <= '0;
          s_mem_req <= 1'b1;
          state     <= StRdSi;
        end
        StRdSi: begin
          s_address <= i;
          s_wen     <= 1'b0;
          d_wen     <= 1'b0;
          state     <= StWtSi;
        end
        StWtSi: state <= StLtSi;
        StLtSi: begin
          si    <= s_q;
          j     <= j + s_q;
          state <= StRdSj;
        end
        StRdSj: begin
          s_address <= j;
          state     <= StWtSj;
        end
        StWtSj: state <= StLtSj;
        StLtSj: begin
          sj    <= s_q;
          state <= StWrSi;
        end
        // Swap: S[i] <= S[j] then S[j] <= S[i]; i==j rewrites the same value twice.
        StWrSi: begin
          s_address <= i;
          s_data    <= sj;
          s_wen     <= 1'b1;
          state     <= StWrSj;
        end
        StWrSj: begin
          s_address <= j;
          s_data    <= si;
          s_wen     <= 1'b1;
          state     <= StRdF;
        end
        StRdF: begin
          s_wen       <= 1'b0;
          s_address   <= si + sj;
          rom_address <= k;
          state       <= StWtF;
        end
        StWtF: state <= StLtF;
        StLtF: begin
          f     <= s_q ^ rom_q;
          state <= StWrOut;
        end
        StWrOut: begin
          d_address <= k;
          d_data    <= f;
          d_wen     <= 1'b1;
          if (k == LastK) begin
            finish    <= 1'b1;
            s_mem_req <= 1'b0;
            state     <= StDone;
          end else begin
            k     <= k + 1'b1;
            i     <= i + 8'd1;
            state <= StRdSi;
          end
        end
        StDone: begin
          s_wen     <= 1'b0;
          d_wen     <= 1'b0;
          s_mem_req <= 1'b0;
          if (start) begin
            finish    <= 1'b0;
            s_mem_req <= 1'b1;
            state     <= StInit;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule
